// File: rtl/stream_credit_sender.sv
// Credit-based stream sender: forwards upstream words onto a link with no backpressure.
// Each word costs one credit, and the remote receiver returns credits one pulse at a time.
module stream_credit_sender #(
    parameter int  DATA_WIDTH = 32,
    parameter type T          = logic [DATA_WIDTH-1:0],
    parameter int  CREDITS    = 8,
    parameter int  CNT_WIDTH  = $clog2(CREDITS + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  T                     data_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    output T                     data_o,
    output logic                 valid_o,
    input  logic                 credit_i,
    output logic [CNT_WIDTH-1:0] credits_o,
    output logic [CNT_WIDTH-1:0] in_flight_o,
    output logic                 err_o
);

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] C_MAX = CNT_WIDTH'(CREDITS);
    localparam logic [CNT_WIDTH-1:0] C_ONE = CNT_WIDTH'(1);

    state_t               r_state;
    logic [CNT_WIDTH-1:0] r_credits;
    logic                 r_valid;
    T                     r_data;
    logic                 r_err;

    logic                 w_ready;
    logic                 w_hs;

    // Ready depends only on state, flush and the counter, so it never loops back through valid_i.
    assign w_ready = (r_state == RUN) && !flush_i && (r_credits != '0);
    assign w_hs    = valid_i && w_ready;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= INIT;
            r_credits <= C_MAX;
            r_valid   <= 1'b0;
            r_data    <= '0;
            r_err     <= 1'b0;
        end else if (flush_i) begin
            r_state   <= FLUSH;
            r_credits <= C_MAX;
            r_valid   <= 1'b0;
        end else begin
            r_state <= RUN;
            r_valid <= w_hs;
            if (w_hs) begin
                r_data <= data_i;
            end
            // A returned credit is dropped while the remote FIFO is being flushed.
            if (r_state != FLUSH) begin
                if (w_hs && !credit_i) begin
                    r_credits <= r_credits - C_ONE;
                end else if (!w_hs && credit_i) begin
                    if (r_credits == C_MAX) begin
                        r_err <= 1'b1;
                    end else begin
                        r_credits <= r_credits + C_ONE;
                    end
                end
            end
        end
    end

    assign ready_o     = w_ready;
    assign data_o      = r_data;
    assign valid_o     = r_valid;
    assign credits_o   = r_credits;
    assign in_flight_o = C_MAX - r_credits;
    assign err_o       = r_err;

endmodule

// File: tb/tb_stream_credit_sender.sv
// Directed bench for stream_credit_sender with default parameters (CREDITS = 8, 32-bit payload).
module tb_stream_credit_sender;

    logic        clk_i    = 1'b0;
    logic        rst_i    = 1'b1;
    logic        flush_i  = 1'b0;
    logic [31:0] data_i   = '0;
    logic        valid_i  = 1'b0;
    logic        ready_o;
    logic [31:0] data_o;
    logic        valid_o;
    logic        credit_i = 1'b0;
    logic [3:0]  credits_o;
    logic [3:0]  in_flight_o;
    logic        err_o;

    int checks = 0;
    int errors = 0;

    stream_credit_sender dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .flush_i    (flush_i),
        .data_i     (data_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .credit_i   (credit_i),
        .credits_o  (credits_o),
        .in_flight_o(in_flight_o),
        .err_o      (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset;
        #12;
        checks++; if (valid_o !== 1'b0)    begin errors++; $display("FAIL rst_valid: got %0h expected 0", valid_o); end
        checks++; if (credits_o !== 4'd8)  begin errors++; $display("FAIL rst_credits: got %0d expected 8", credits_o); end
        checks++; if (in_flight_o !== 4'd0) begin errors++; $display("FAIL rst_in_flight: got %0d expected 0", in_flight_o); end
        checks++; if (err_o !== 1'b0)      begin errors++; $display("FAIL rst_err: got %0h expected 0", err_o); end
        checks++; if (ready_o !== 1'b0)    begin errors++; $display("FAIL rst_ready: got %0h expected 0", ready_o); end
        checks++; if (data_o !== 32'h0)    begin errors++; $display("FAIL rst_data: got %0h expected 0", data_o); end
        tick();
        rst_i = 1'b0;
        #1;
        checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL init_ready: got %0h expected 0", ready_o); end
        tick();
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL run_ready: got %0h expected 1", ready_o); end
    endtask

    task automatic test_burst;
        valid_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            data_i = 32'hA0 + 32'(i);
            tick();
            checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL burst_valid[%0d]: got %0h expected 1", i, valid_o); end
            checks++; if (data_o !== 32'hA0 + 32'(i)) begin errors++; $display("FAIL burst_data[%0d]: got %0h expected %0h", i, data_o, 32'hA0 + 32'(i)); end
            checks++; if (credits_o !== 4'(7 - i)) begin errors++; $display("FAIL burst_credits[%0d]: got %0d expected %0d", i, credits_o, 7 - i); end
        end
        checks++; if (ready_o !== 1'b0)     begin errors++; $display("FAIL burst_ready: got %0h expected 0", ready_o); end
        checks++; if (in_flight_o !== 4'd8) begin errors++; $display("FAIL burst_in_flight: got %0d expected 8", in_flight_o); end
        data_i = 32'hBAD;
        tick();
        checks++; if (valid_o !== 1'b0)  begin errors++; $display("FAIL stall_valid: got %0h expected 0", valid_o); end
        checks++; if (data_o !== 32'hA7) begin errors++; $display("FAIL stall_data_hold: got %0h expected a7", data_o); end
        checks++; if (credits_o !== 4'd0) begin errors++; $display("FAIL stall_credits: got %0d expected 0", credits_o); end
    endtask

    task automatic test_credit_return;
        credit_i = 1'b1;
        tick();
        credit_i = 1'b0;
        checks++; if (credits_o !== 4'd1) begin errors++; $display("FAIL ret_credits: got %0d expected 1", credits_o); end
        checks++; if (valid_o !== 1'b0)   begin errors++; $display("FAIL ret_valid: got %0h expected 0", valid_o); end
        checks++; if (ready_o !== 1'b1)   begin errors++; $display("FAIL ret_ready: got %0h expected 1", ready_o); end
        data_i = 32'h55;
        tick();
        checks++; if (valid_o !== 1'b1)   begin errors++; $display("FAIL ret_send_valid: got %0h expected 1", valid_o); end
        checks++; if (data_o !== 32'h55)  begin errors++; $display("FAIL ret_send_data: got %0h expected 55", data_o); end
        checks++; if (credits_o !== 4'd0) begin errors++; $display("FAIL ret_send_credits: got %0d expected 0", credits_o); end
        checks++; if (ready_o !== 1'b0)   begin errors++; $display("FAIL ret_send_ready: got %0h expected 0", ready_o); end
    endtask

    task automatic test_simultaneous;
        valid_i  = 1'b0;
        credit_i = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        checks++; if (credits_o !== 4'd3) begin errors++; $display("FAIL sim_pre_credits: got %0d expected 3", credits_o); end
        valid_i = 1'b1;
        data_i  = 32'h33;
        tick();
        valid_i  = 1'b0;
        credit_i = 1'b0;
        checks++; if (credits_o !== 4'd3) begin errors++; $display("FAIL sim_credits: got %0d expected 3", credits_o); end
        checks++; if (valid_o !== 1'b1)   begin errors++; $display("FAIL sim_valid: got %0h expected 1", valid_o); end
        checks++; if (data_o !== 32'h33)  begin errors++; $display("FAIL sim_data: got %0h expected 33", data_o); end
        tick();
        checks++; if (valid_o !== 1'b0)   begin errors++; $display("FAIL sim_idle_valid: got %0h expected 0", valid_o); end
    endtask

    task automatic test_overflow;
        credit_i = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        checks++; if (credits_o !== 4'd8) begin errors++; $display("FAIL ovf_pre_credits: got %0d expected 8", credits_o); end
        checks++; if (err_o !== 1'b0)     begin errors++; $display("FAIL ovf_pre_err: got %0h expected 0", err_o); end
        tick();
        credit_i = 1'b0;
        checks++; if (err_o !== 1'b1)     begin errors++; $display("FAIL ovf_err: got %0h expected 1", err_o); end
        checks++; if (credits_o !== 4'd8) begin errors++; $display("FAIL ovf_credits: got %0d expected 8", credits_o); end
    endtask

    task automatic test_flush;
        valid_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            data_i = 32'hC0 + 32'(i);
            tick();
        end
        checks++; if (credits_o !== 4'd2) begin errors++; $display("FAIL fl_pre_credits: got %0d expected 2", credits_o); end
        data_i  = 32'hEE;
        flush_i = 1'b1;
        #1;
        checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL fl_ready: got %0h expected 0", ready_o); end
        tick();
        checks++; if (valid_o !== 1'b0)   begin errors++; $display("FAIL fl_valid0: got %0h expected 0", valid_o); end
        checks++; if (credits_o !== 4'd8) begin errors++; $display("FAIL fl_credits0: got %0d expected 8", credits_o); end
        checks++; if (data_o !== 32'hC5)  begin errors++; $display("FAIL fl_data_hold: got %0h expected c5", data_o); end
        tick();
        flush_i = 1'b0;
        checks++; if (valid_o !== 1'b0)   begin errors++; $display("FAIL fl_valid1: got %0h expected 0", valid_o); end
        checks++; if (err_o !== 1'b1)     begin errors++; $display("FAIL fl_err_sticky: got %0h expected 1", err_o); end
        #1;
        checks++; if (ready_o !== 1'b0)   begin errors++; $display("FAIL fl_exit_ready: got %0h expected 0", ready_o); end
        tick();
        checks++; if (valid_o !== 1'b0)   begin errors++; $display("FAIL fl_exit_valid: got %0h expected 0", valid_o); end
        checks++; if (ready_o !== 1'b1)   begin errors++; $display("FAIL fl_run_ready: got %0h expected 1", ready_o); end
        tick();
        checks++; if (valid_o !== 1'b1)   begin errors++; $display("FAIL fl_resume_valid: got %0h expected 1", valid_o); end
        checks++; if (data_o !== 32'hEE)  begin errors++; $display("FAIL fl_resume_data: got %0h expected ee", data_o); end
        checks++; if (credits_o !== 4'd7) begin errors++; $display("FAIL fl_resume_credits: got %0d expected 7", credits_o); end
    endtask

    task automatic test_async_reset;
        #2;
        rst_i = 1'b1;
        #1;
        checks++; if (valid_o !== 1'b0)    begin errors++; $display("FAIL arst_valid: got %0h expected 0", valid_o); end
        checks++; if (credits_o !== 4'd8)  begin errors++; $display("FAIL arst_credits: got %0d expected 8", credits_o); end
        checks++; if (in_flight_o !== 4'd0) begin errors++; $display("FAIL arst_in_flight: got %0d expected 0", in_flight_o); end
        checks++; if (err_o !== 1'b0)      begin errors++; $display("FAIL arst_err: got %0h expected 0", err_o); end
        checks++; if (ready_o !== 1'b0)    begin errors++; $display("FAIL arst_ready: got %0h expected 0", ready_o); end
        checks++; if (data_o !== 32'h0)    begin errors++; $display("FAIL arst_data: got %0h expected 0", data_o); end
        valid_i = 1'b0;
        tick();
        rst_i = 1'b0;
        tick();
        tick();
        checks++; if (valid_o !== 1'b0)    begin errors++; $display("FAIL arst_after_valid: got %0h expected 0", valid_o); end
    endtask

    initial begin
        test_reset();
        test_burst();
        test_credit_return();
        test_simultaneous();
        test_overflow();
        test_flush();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stream_credit_sender.md
STREAM_CREDIT_SENDER -- requirements
Module: stream_credit_sender

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 32, payload width when T is the default type.
REQ-002 SHALL provide parameter T, default logic [DATA_WIDTH-1:0], payload type.
REQ-003 SHALL provide parameter CREDITS, default 8, depth of the remote receive FIFO; legal range 1 to 2**16.
REQ-004 SHALL provide parameter CNT_WIDTH, default $clog2(CREDITS+1), width of the credit counter; not to be overridden.
REQ-005 SHALL provide port clk_i, input, 1 bit, the single clock.
REQ-006 SHALL provide port rst_i, input, 1 bit, reset that is asynchronous and active-high.
REQ-007 SHALL provide port flush_i, input, 1 bit, synchronous flush.
REQ-008 SHALL provide port data_i, input, T, upstream payload.
REQ-009 SHALL provide port valid_i, input, 1 bit, upstream valid.
REQ-010 SHALL provide port ready_o, output, 1 bit, upstream ready.
REQ-011 SHALL provide port data_o, output, T, link payload.
REQ-012 SHALL provide port valid_o, output, 1 bit, link valid, one cycle per word, with no backpressure.
REQ-013 SHALL provide port credit_i, input, 1 bit, one pulse returns one credit.
REQ-014 SHALL provide port credits_o, output, CNT_WIDTH bits, credits currently available.
REQ-015 SHALL provide port in_flight_o, output, CNT_WIDTH bits, equal to CREDITS minus credits_o.
REQ-016 SHALL provide port err_o, output, 1 bit, sticky credit-overflow flag.

Function
REQ-017 SHALL implement states INIT, RUN and FLUSH.
REQ-018 SHALL enter INIT on reset, then move to RUN on the next clock edge; ready_o SHALL be 0 in INIT.
REQ-019 SHALL in RUN drive ready_o = (credits != 0) combinationally from the counter, never from valid_i.
REQ-020 SHALL treat a handshake (valid_i && ready_o) as: data_o <= data_i and valid_o <= 1 on the next edge, and credits decrement by 1; latency is exactly 1 cycle.
REQ-021 SHALL drive valid_o to 0 in any cycle following a cycle with no handshake; data_o SHALL hold its last value.
REQ-022 SHALL increment credits by 1 on credit_i when credits < CREDITS.
REQ-023 SHALL leave credits unchanged when a handshake and credit_i occur in the same cycle, with the word sent.
REQ-024 SHALL, on credit_i with credits == CREDITS and no same-cycle handshake, keep credits saturated and set err_o.
REQ-025 SHALL hold err_o at 1 until reset; flush SHALL NOT clear it.
REQ-026 SHALL, on flush_i in any state, move to FLUSH on the next edge: credits <= CREDITS, valid_o <= 0, and no handshake in the flush_i cycle (ready_o = 0 while flush_i = 1).
REQ-027 SHALL ignore credit_i in FLUSH and in the flush_i cycle.
REQ-028 SHALL return from FLUSH to RUN on the first edge after flush_i deasserts.
REQ-029 SHALL allow back-to-back handshakes every cycle while credits remain; at credits == 1 a handshake SHALL drop ready_o in the following cycle unless credit_i is also asserted.
REQ-030 SHALL compute in_flight_o without overflow in CNT_WIDTH bits, and SHALL guarantee credits_o <= CREDITS at all times.

Reset
REQ-031 SHALL, while rst_i = 1, force state = INIT, credits_o = CREDITS, in_flight_o = 0, valid_o = 0, data_o = 0, err_o = 0 and ready_o = 0, independent of clk_i.
REQ-032 SHALL, when reset is asserted mid-transfer, discard any pending word; valid_o SHALL fall immediately and asynchronously.

Verification
REQ-033 SHALL pass: reset release, CREDITS = 8, valid_i held high, no credit_i -> 8 words on valid_o on consecutive cycles after INIT, then ready_o = 0, credits_o = 0, in_flight_o = 8.
REQ-034 SHALL pass: credits_o = 0, then one credit_i pulse -> ready_o = 1 next cycle; one word sent; credits_o returns to 0.
REQ-035 SHALL pass: credits_o = 3, handshake plus credit_i in the same cycle -> credits_o stays 3 and valid_o = 1 the next cycle with the matching data.
REQ-036 SHALL pass: credits_o = 8, credit_i pulse -> err_o = 1 and credits_o = 8; err_o stays 1 through a subsequent flush.
REQ-037 SHALL pass: credits_o = 2 with valid_i high, flush_i for 2 cycles -> no word sent during the flush, credits_o = 8, then resume in RUN.
REQ-038 SHALL pass: rst_i asserted asynchronously between edges while valid_o = 1 -> valid_o = 0 and credits_o = 8 without waiting for a clock edge.
